// File: rtl/alu_result_sequencer.sv
// Holds the ALU's ZHI/ZLO result pair and drains it onto the internal bus one word at a time.
// Two-word results go out low word first, pulsing lo_we/hi_we as each word is accepted.
module alu_result_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] zhi_in,
  input  logic [WIDTH-1:0] zlo_in,
  input  logic             zin,
  input  logic             wide,
  input  logic             drain,
  input  logic             bus_ready,
  output logic [WIDTH-1:0] bus_out,
  output logic             bus_valid,
  output logic             lo_we,
  output logic             hi_we,
  output logic             busy,
  output logic             done,
  output logic             z_zero,
  output logic             z_neg
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FULL    = 2'd1,
    SEND_LO = 2'd2,
    SEND_HI = 2'd3
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] z_hi_q;
  logic [WIDTH-1:0] z_lo_q;
  logic             wide_q;
  logic             z_zero_q;
  logic             z_neg_q;
  logic             done_q;

  logic             capture;
  logic             sending;
  logic             accept;
  logic             last_accept;
  logic             zero_d;
  logic             neg_d;

  // Captures are only honoured while no transfer is in flight.
  assign capture = zin && ((state_q == IDLE) || (state_q == FULL));

  // Narrow results take their flags from the low word alone.
  assign zero_d = wide ? ({zhi_in, zlo_in} == '0) : (zlo_in == '0);
  assign neg_d  = wide ? zhi_in[WIDTH-1] : zlo_in[WIDTH-1];

  assign sending     = (state_q == SEND_LO) || (state_q == SEND_HI);
  assign accept      = sending && bus_ready;
  assign last_accept = accept && ((state_q == SEND_HI) || !wide_q);

  assign bus_valid = sending;
  assign busy      = sending;
  assign lo_we     = accept && (state_q == SEND_LO) && wide_q;
  assign hi_we     = accept && (state_q == SEND_HI);
  assign done      = done_q;
  assign z_zero    = z_zero_q;
  assign z_neg     = z_neg_q;

  always_comb begin
    bus_out = '0;
    case (state_q)
      SEND_LO: bus_out = z_lo_q;
      SEND_HI: bus_out = z_hi_q;
      default: bus_out = '0;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      z_hi_q   <= '0;
      z_lo_q   <= '0;
      wide_q   <= 1'b0;
      z_zero_q <= 1'b0;
      z_neg_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= last_accept;

      if (capture) begin
        z_hi_q   <= zhi_in;
        z_lo_q   <= zlo_in;
        wide_q   <= wide;
        z_zero_q <= zero_d;
        z_neg_q  <= neg_d;
      end

      case (state_q)
        IDLE: begin
          // A drain arriving with nothing held is dropped, even alongside a capture.
          if (zin) state_q <= FULL;
        end
        FULL: begin
          if (drain) state_q <= SEND_LO;
        end
        SEND_LO: begin
          if (bus_ready) state_q <= wide_q ? SEND_HI : IDLE;
        end
        SEND_HI: begin
          if (bus_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_result_sequencer.sv
// Directed-vector bench for alu_result_sequencer; each task drives one scenario and checks inline.
module tb_alu_result_sequencer;

  localparam int WIDTH = 32;

  logic             clk;
  logic             clr;
  logic [WIDTH-1:0] zhi_in;
  logic [WIDTH-1:0] zlo_in;
  logic             zin;
  logic             wide;
  logic             drain;
  logic             bus_ready;
  logic [WIDTH-1:0] bus_out;
  logic             bus_valid;
  logic             lo_we;
  logic             hi_we;
  logic             busy;
  logic             done;
  logic             z_zero;
  logic             z_neg;

  int vectors;
  int miscompares;

  alu_result_sequencer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .clr       (clr),
    .zhi_in    (zhi_in),
    .zlo_in    (zlo_in),
    .zin       (zin),
    .wide      (wide),
    .drain     (drain),
    .bus_ready (bus_ready),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .lo_we     (lo_we),
    .hi_we     (hi_we),
    .busy      (busy),
    .done      (done),
    .z_zero    (z_zero),
    .z_neg     (z_neg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and land 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [WIDTH-1:0] hi, input logic [WIDTH-1:0] lo, input logic w);
    zhi_in = hi;
    zlo_in = lo;
    wide   = w;
    zin    = 1'b1;
    step();
    zin = 1'b0;
  endtask

  // Control bundle order: {bus_valid, lo_we, hi_we, busy, done}
  task automatic test_reset();
    logic [4:0] ctl;
    clr = 1'b0; zin = 1'b0; wide = 1'b0; drain = 1'b0; bus_ready = 1'b0;
    zhi_in = '0; zlo_in = '0;
    #2;
    ctl = {bus_valid, lo_we, hi_we, busy, done};
    vectors++;
    if (ctl !== 5'b00000 || bus_out !== '0 || z_zero !== 1'b0 || z_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_state: ctl=%b bus_out=%h z_zero=%b z_neg=%b, expected all 0", ctl, bus_out, z_zero, z_neg);
    end
    step();
    clr = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    logic [4:0] ctl;
    capture(32'hDEAD_BEEF, 32'h0000_0005, 1'b0);
    vectors++;
    if (z_zero !== 1'b0 || z_neg !== 1'b0 || bus_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL single_flags: z_zero=%b z_neg=%b bus_valid=%b, expected 0 0 0", z_zero, z_neg, bus_valid);
    end
    drain = 1'b1; bus_ready = 1'b1;
    step();
    drain = 1'b0;
    ctl = {bus_valid, lo_we, hi_we, busy, done};
    vectors++;
    if (ctl !== 5'b10010 || bus_out !== 32'h0000_0005) begin
      miscompares++;
      $display("FAIL single_word: ctl=%b bus_out=%h, expected 10010 00000005", ctl, bus_out);
    end
    step();
    ctl = {bus_valid, lo_we, hi_we, busy, done};
    vectors++;
    if (ctl !== 5'b00001 || bus_out !== '0) begin
      miscompares++;
      $display("FAIL single_done: ctl=%b bus_out=%h, expected 00001 00000000", ctl, bus_out);
    end
    step();
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL single_done_pulse: done=%b, expected 0", done);
    end
    bus_ready = 1'b0;
  endtask

  task automatic test_multiply();
    logic [4:0] ctl;
    capture(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1);
    vectors++;
    if (z_neg !== 1'b1 || z_zero !== 1'b0) begin
      miscompares++;
      $display("FAIL mul_flags: z_neg=%b z_zero=%b, expected 1 0", z_neg, z_zero);
    end
    drain = 1'b1; bus_ready = 1'b1;
    step();
    drain = 1'b0;
    ctl = {bus_valid, lo_we, hi_we, busy, done};
    vectors++;
    if (ctl !== 5'b11010 || bus_out !== 32'hFFFF_FFFE) begin
      miscompares++;
      $display("FAIL mul_lo: ctl=%b bus_out=%h, expected 11010 fffffffe", ctl, bus_out);
    end
    step();
    ctl = {bus_valid, lo_we, hi_we, busy, done};
    vectors++;
    if (ctl !== 5'b10110 || bus_out !== 32'hFFFF_FFFF) begin
      miscompares++;
      $display("FAIL mul_hi: ctl=%b bus_out=%h, expected 10110 ffffffff", ctl, bus_out);
    end
    step();
    ctl = {bus_valid, lo_we, hi_we, busy, done};
    vectors++;
    if (ctl !== 5'b00001) begin
      miscompares++;
      $display("FAIL mul_done: ctl=%b, expected 00001", ctl);
    end
    bus_ready = 1'b0;
    step();
  endtask

  task automatic test_backpressure();
    logic [4:0]       ctl;
    logic [4:0]       exp_ctl;
    logic [WIDTH-1:0] exp_out;
    int               lo_pulses;
    int               hi_pulses;
    lo_pulses = 0;
    hi_pulses = 0;
    capture(32'hA5A5_0001, 32'h1234_5678, 1'b1);
    drain = 1'b1; bus_ready = 1'b0;
    step();
    drain = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      bus_ready = (c == 4) || (c == 7);
      #1;
      if (c <= 4) begin
        exp_out = 32'h1234_5678;
        exp_ctl = {1'b1, (c == 4), 1'b0, 1'b1, 1'b0};
      end else if (c <= 7) begin
        exp_out = 32'hA5A5_0001;
        exp_ctl = {1'b1, 1'b0, (c == 7), 1'b1, 1'b0};
      end else begin
        exp_out = '0;
        exp_ctl = 5'b00001;
      end
      ctl = {bus_valid, lo_we, hi_we, busy, done};
      if (lo_we === 1'b1) lo_pulses++;
      if (hi_we === 1'b1) hi_pulses++;
      vectors++;
      if (ctl !== exp_ctl || bus_out !== exp_out) begin
        miscompares++;
        $display("FAIL bp_cycle%0d: ctl=%b bus_out=%h, expected %b %h", c, ctl, bus_out, exp_ctl, exp_out);
      end
      step();
    end
    bus_ready = 1'b0;
    vectors++;
    if (lo_pulses != 1 || hi_pulses != 1) begin
      miscompares++;
      $display("FAIL bp_we_count: lo=%0d hi=%0d, expected 1 1", lo_pulses, hi_pulses);
    end
  endtask

  task automatic test_overwrite_ignore();
    capture(32'h0, 32'h0000_0001, 1'b0);
    capture(32'h0, 32'h0000_0002, 1'b0);
    drain = 1'b1; bus_ready = 1'b0;
    step();
    drain = 1'b0;
    vectors++;
    if (bus_valid !== 1'b1 || bus_out !== 32'h0000_0002) begin
      miscompares++;
      $display("FAIL overwrite: bus_valid=%b bus_out=%h, expected 1 00000002", bus_valid, bus_out);
    end
    capture(32'h0, 32'h0000_0003, 1'b0);
    capture(32'h0, 32'h0000_0000, 1'b0);
    vectors++;
    if (bus_out !== 32'h0000_0002 || z_zero !== 1'b0 || z_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_zin: bus_out=%h z_zero=%b z_neg=%b, expected 00000002 0 0", bus_out, z_zero, z_neg);
    end
    bus_ready = 1'b1;
    step();
    bus_ready = 1'b0;
    vectors++;
    if (done !== 1'b1 || bus_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ignore_done: done=%b bus_valid=%b, expected 1 0", done, bus_valid);
    end
    // Ignored captures must not have refilled the holder.
    drain = 1'b1;
    step();
    drain = 1'b0;
    vectors++;
    if (bus_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL no_redrain: bus_valid=%b busy=%b, expected 0 0", bus_valid, busy);
    end
  endtask

  task automatic test_back_to_back();
    capture(32'h0, 32'h0000_0007, 1'b0);
    zlo_in = 32'h0000_0009; zin = 1'b1; drain = 1'b1; bus_ready = 1'b0;
    step();
    zin = 1'b0; drain = 1'b0;
    vectors++;
    if (bus_valid !== 1'b1 || bus_out !== 32'h0000_0009) begin
      miscompares++;
      $display("FAIL cap_drain_full: bus_valid=%b bus_out=%h, expected 1 00000009", bus_valid, bus_out);
    end
    bus_ready = 1'b1;
    step();
    step();
    bus_ready = 1'b0;
    zlo_in = 32'h0000_000A; zin = 1'b1; drain = 1'b1;
    step();
    zin = 1'b0; drain = 1'b0;
    vectors++;
    if (bus_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cap_drain_idle: bus_valid=%b busy=%b, expected 0 0", bus_valid, busy);
    end
    drain = 1'b1;
    step();
    drain = 1'b0;
    vectors++;
    if (bus_valid !== 1'b1 || bus_out !== 32'h0000_000A) begin
      miscompares++;
      $display("FAIL redrain: bus_valid=%b bus_out=%h, expected 1 0000000a", bus_valid, bus_out);
    end
    bus_ready = 1'b1;
    step();
    step();
    bus_ready = 1'b0;
  endtask

  task automatic test_zero_flag();
    capture(32'h0000_0001, 32'h0000_0000, 1'b0);
    vectors++;
    if (z_zero !== 1'b1 || z_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_narrow: z_zero=%b z_neg=%b, expected 1 0", z_zero, z_neg);
    end
    capture(32'h0000_0001, 32'h0000_0000, 1'b1);
    vectors++;
    if (z_zero !== 1'b0 || z_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_wide: z_zero=%b z_neg=%b, expected 0 0", z_zero, z_neg);
    end
    capture(32'h8000_0000, 32'h0000_0001, 1'b0);
    vectors++;
    if (z_zero !== 1'b0 || z_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL neg_narrow: z_zero=%b z_neg=%b, expected 0 0", z_zero, z_neg);
    end
    capture(32'h0000_0000, 32'h0000_0000, 1'b1);
    vectors++;
    if (z_zero !== 1'b1 || z_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_wide_all: z_zero=%b z_neg=%b, expected 1 0", z_zero, z_neg);
    end
  endtask

  task automatic test_reset_mid_transfer();
    logic [4:0] ctl;
    capture(32'hCAFE_0000, 32'h0000_BABE, 1'b1);
    drain = 1'b1; bus_ready = 1'b1;
    step();
    drain = 1'b0;
    step();
    vectors++;
    if (bus_valid !== 1'b1 || hi_we !== 1'b1 || bus_out !== 32'hCAFE_0000) begin
      miscompares++;
      $display("FAIL pre_reset_hi: bus_valid=%b hi_we=%b bus_out=%h, expected 1 1 cafe0000", bus_valid, hi_we, bus_out);
    end
    clr = 1'b0;
    #1;
    ctl = {bus_valid, lo_we, hi_we, busy, done};
    vectors++;
    if (ctl !== 5'b00000 || bus_out !== '0 || z_zero !== 1'b0 || z_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: ctl=%b bus_out=%h z_zero=%b z_neg=%b, expected all 0", ctl, bus_out, z_zero, z_neg);
    end
    zlo_in = 32'hFFFF_FFFF; zin = 1'b1; drain = 1'b1;
    step();
    ctl = {bus_valid, lo_we, hi_we, busy, done};
    vectors++;
    if (ctl !== 5'b00000 || bus_out !== '0 || z_neg !== 1'b0) begin
      miscompares++;
      $display("FAIL held_reset: ctl=%b bus_out=%h z_neg=%b, expected all 0", ctl, bus_out, z_neg);
    end
    zin = 1'b0; drain = 1'b0; bus_ready = 1'b0;
    clr = 1'b1;
    step();
    drain = 1'b1;
    step();
    drain = 1'b0;
    step();
    vectors++;
    if (bus_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_drain: bus_valid=%b busy=%b, expected 0 0", bus_valid, busy);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single_word();
    test_multiply();
    test_backpressure();
    test_overwrite_ignore();
    test_back_to_back();
    test_zero_flag();
    test_reset_mid_transfer();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
